// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type and framebuffer address helper.
package vga_pkg;

    localparam int unsigned H_ACTIVE        = 640;
    localparam int unsigned V_ACTIVE        = 480;
    localparam int unsigned DEF_SCALE_SHIFT = 2;

    typedef logic [11:0] rgb12_t;

    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
        logic active;
    } pipe_ctl_t;

    // Linear byte address of screen pixel (x,y) in the given page of the scaled framebuffer.
    function automatic logic [31:0] fb_addr(input logic [9:0]  x,
                                            input logic [8:0]  y,
                                            input logic        page,
                                            input int unsigned shift = DEF_SCALE_SHIFT);
        logic [31:0] fb_w;
        logic [31:0] fb_h;
        fb_w = 32'(H_ACTIVE >> shift);
        fb_h = 32'(V_ACTIVE >> shift);
        return (page ? fb_w * fb_h : 32'd0) + 32'(y >> shift) * fb_w + 32'(x >> shift);
    endfunction

endpackage

// File: rtl/vga_palette_ram.sv
// 256x12 palette: synchronous write and read; a same-address collision returns the old entry.
module vga_palette_ram
    import vga_pkg::*;
(
    input  logic       clk_i,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  rgb12_t     wdata_i,
    input  logic [7:0] raddr_i,
    output rgb12_t     rdata_o
);

    rgb12_t mem_q [256];
    rgb12_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_pixel_pipeline.sv
// Three-strobe pixel pipeline: framebuffer fetch, palette lookup, aligned syncs and page flipping.
// Optional colour-bar generator enabled by VGA_PIXEL_PIPELINE_TEST_PATTERN_EN (adds i_test).
module vga_pixel_pipeline
    import vga_pkg::*;
#(
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned FRAME_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_stb,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic               i_active,
    input  logic               i_animate,
    input  logic [9:0]         i_x,
    input  logic [8:0]         i_y,
    output logic [ADDR_W-1:0]  o_rd_addr,
    output logic               o_rd_en,
    input  logic [7:0]         i_rd_data,
    input  logic               i_pal_we,
    input  logic [7:0]         i_pal_addr,
    input  rgb12_t             i_pal_data,
    input  logic               i_swap_req,
    output logic               o_swap_ack,
    output logic               o_page,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_hs,
    output logic               o_vs,
    output rgb12_t             o_rgb
`ifdef VGA_PIXEL_PIPELINE_TEST_PATTERN_EN
    ,
    input  logic               i_test
`endif
);

    pipe_ctl_t          ctl_a_q, ctl_a_d, ctl_b_q, ctl_b_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               rd_en_q, rd_en_d;
    logic [7:0]         idx_q, idx_d;
    rgb12_t             rgb_q, rgb_d;
    rgb12_t             pal_rdata;
    rgb12_t             pix_rgb;
    logic               hs_q, hs_d, vs_q, vs_d;
    logic               page_q, page_d, pend_q, pend_d, ack_q, ack_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               frame_tick;
    logic               flip;

    vga_palette_ram u_palette (
        .clk_i   (i_clk),
        .we_i    (i_pal_we),
        .waddr_i (i_pal_addr),
        .wdata_i (i_pal_data),
        .raddr_i (idx_q),
        .rdata_o (pal_rdata)
    );

`ifdef VGA_PIXEL_PIPELINE_TEST_PATTERN_EN
    logic [2:0] bar_a_q, bar_b_q;

    always_ff @(posedge i_clk) begin
        if (i_pix_stb) begin
            bar_a_q <= i_x[9:7];
            bar_b_q <= bar_a_q;
        end
    end

    assign pix_rgb = i_test ? {{4{bar_b_q[0]}}, {4{bar_b_q[1]}}, {4{bar_b_q[2]}}} : pal_rdata;
`else
    assign pix_rgb = pal_rdata;
`endif

    // A request arriving on the flip clock is served at once rather than left pending.
    assign frame_tick = i_animate & i_pix_stb;
    assign flip       = frame_tick & (pend_q | i_swap_req);

    always_comb begin
        rd_addr_d = rd_addr_q;
        ctl_a_d   = ctl_a_q;
        ctl_b_d   = ctl_b_q;
        idx_d     = idx_q;
        rgb_d     = rgb_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        rd_en_d   = i_pix_stb;
        pend_d    = flip ? 1'b0 : (pend_q | i_swap_req);
        page_d    = page_q ^ flip;
        ack_d     = flip;
        frame_d   = frame_tick ? frame_q + FRAME_W'(1) : frame_q;
        if (i_pix_stb) begin
            rd_addr_d = ADDR_W'(fb_addr(i_x, i_y, page_q, SCALE_SHIFT));
            ctl_a_d   = '{valid: 1'b1, hs: i_hs, vs: i_vs, active: i_active};
            idx_d     = i_rd_data;
            ctl_b_d   = ctl_a_q;
            rgb_d     = ctl_b_q.active ? pix_rgb : 12'h000;
            hs_d      = ctl_b_q.valid ? ctl_b_q.hs : 1'b1;
            vs_d      = ctl_b_q.valid ? ctl_b_q.vs : 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            ctl_a_q   <= '0;
            ctl_b_q   <= '0;
            idx_q     <= '0;
            rgb_q     <= 12'h000;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            page_q    <= 1'b0;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            frame_q   <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            ctl_a_q   <= ctl_a_d;
            ctl_b_q   <= ctl_b_d;
            idx_q     <= idx_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            page_q    <= page_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            frame_q   <= frame_d;
        end
    end

    assign o_rd_addr  = rd_addr_q;
    assign o_rd_en    = rd_en_q;
    assign o_rgb      = rgb_q;
    assign o_hs       = hs_q;
    assign o_vs       = vs_q;
    assign o_page     = page_q;
    assign o_swap_ack = ack_q;
    assign o_frame    = frame_q;

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Directed bench for vga_pixel_pipeline with a behavioural framebuffer model.
module tb_vga_pixel_pipeline;

    localparam int unsigned FB_SIZE = 38400;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pix_stb = 1'b0;
    logic        i_hs = 1'b1;
    logic        i_vs = 1'b1;
    logic        i_active = 1'b0;
    logic        i_animate = 1'b0;
    logic [9:0]  i_x = '0;
    logic [8:0]  i_y = '0;
    logic [15:0] o_rd_addr;
    logic        o_rd_en;
    logic [7:0]  i_rd_data = '0;
    logic        i_pal_we = 1'b0;
    logic [7:0]  i_pal_addr = '0;
    logic [11:0] i_pal_data = '0;
    logic        i_swap_req = 1'b0;
    logic        o_swap_ack;
    logic        o_page;
    logic [15:0] o_frame;
    logic        o_hs;
    logic        o_vs;
    logic [11:0] o_rgb;

    logic [7:0] fb [FB_SIZE];
    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    vga_pixel_pipeline dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_pix_stb  (i_pix_stb),
        .i_hs       (i_hs),
        .i_vs       (i_vs),
        .i_active   (i_active),
        .i_animate  (i_animate),
        .i_x        (i_x),
        .i_y        (i_y),
        .o_rd_addr  (o_rd_addr),
        .o_rd_en    (o_rd_en),
        .i_rd_data  (i_rd_data),
        .i_pal_we   (i_pal_we),
        .i_pal_addr (i_pal_addr),
        .i_pal_data (i_pal_data),
        .i_swap_req (i_swap_req),
        .o_swap_ack (o_swap_ack),
        .o_page     (o_page),
        .o_frame    (o_frame),
        .o_hs       (o_hs),
        .o_vs       (o_vs),
`ifdef VGA_PIXEL_PIPELINE_TEST_PATTERN_EN
        .i_test     (1'b0),
`endif
        .o_rgb      (o_rgb)
    );

    // Framebuffer: data appears one clock after the read enable and holds until the next read.
    always @(posedge i_clk) begin
        if (o_rd_en && (int'(o_rd_addr) < FB_SIZE)) begin
            i_rd_data <= fb[o_rd_addr];
        end
    end

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        hs;
        logic        vs;
        logic        act;
        logic [15:0] addr;
        logic [11:0] rgb;
        logic        ohs;
        logic        ovs;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // One strobe clock; returns 1 time unit after that edge with the strobe dropped.
    task automatic pulse(input logic [9:0] x, input logic [8:0] y, input logic hs, input logic vs,
                         input logic act, input logic anim, input logic swap);
        i_x = x; i_y = y; i_hs = hs; i_vs = vs; i_active = act;
        i_animate = anim; i_swap_req = swap; i_pix_stb = 1'b1;
        @(posedge i_clk);
        #1;
        i_pix_stb = 1'b0; i_animate = 1'b0; i_swap_req = 1'b0;
    endtask

    task automatic pal_write(input logic [7:0] a, input logic [11:0] d);
        i_pal_we = 1'b1; i_pal_addr = a; i_pal_data = d;
        @(posedge i_clk);
        #1;
        i_pal_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < FB_SIZE; i++) fb[i] = (i < 19200) ? 8'd5 : 8'd9;
        fb[323] = 8'd7;

        //           x    y    hs    vs    act   addr    rgb      ohs   ovs
        tbl[0] = '{  0,   0, 1'b1, 1'b1, 1'b1,     0, 12'h000, 1'b1, 1'b1};
        tbl[1] = '{ 13,   9, 1'b1, 1'b1, 1'b1,   323, 12'h000, 1'b1, 1'b1};
        tbl[2] = '{639, 479, 1'b0, 1'b1, 1'b1, 19199, 12'hABC, 1'b1, 1'b1};
        tbl[3] = '{100, 200, 1'b0, 1'b0, 1'b0,  8025, 12'h123, 1'b1, 1'b1};
        tbl[4] = '{  4,   4, 1'b1, 1'b0, 1'b1,   161, 12'hABC, 1'b0, 1'b1};
        tbl[5] = '{  8,   0, 1'b1, 1'b1, 1'b1,     2, 12'h000, 1'b0, 1'b0};
        tbl[6] = '{  0,   0, 1'b1, 1'b1, 1'b0,     0, 12'hABC, 1'b1, 1'b0};
        tbl[7] = '{  0,   0, 1'b1, 1'b1, 1'b0,     0, 12'hABC, 1'b1, 1'b1};
        tbl[8] = '{  0,   0, 1'b1, 1'b1, 1'b0,     0, 12'h000, 1'b1, 1'b1};

        gap(3);
        chk("rst_rd_addr", 32'(o_rd_addr), 0);
        chk("rst_rd_en",   32'(o_rd_en),   0);
        chk("rst_ack",     32'(o_swap_ack), 0);
        chk("rst_page",    32'(o_page),    0);
        chk("rst_frame",   32'(o_frame),   0);
        chk("rst_hs",      32'(o_hs),      1);
        chk("rst_vs",      32'(o_vs),      1);
        chk("rst_rgb",     32'(o_rgb),     0);
        i_rst = 1'b0;

        pal_write(8'd5, 12'hABC);
        pal_write(8'd7, 12'h123);
        pal_write(8'd9, 12'hF0F);
        gap(2);

        // Outputs after each strobe edge reflect the vector two strobes earlier.
        for (int i = 0; i < 9; i++) begin
            pulse(tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].act, 1'b0, 1'b0);
            chk($sformatf("v%0d_addr", i), 32'(o_rd_addr), 32'(tbl[i].addr));
            chk($sformatf("v%0d_rd_en_hi", i), 32'(o_rd_en), 1);
            chk($sformatf("v%0d_rgb", i), 32'(o_rgb), 32'(tbl[i].rgb));
            chk($sformatf("v%0d_hs", i), 32'(o_hs), 32'(tbl[i].ohs));
            chk($sformatf("v%0d_vs", i), 32'(o_vs), 32'(tbl[i].ovs));
            gap(1);
            chk($sformatf("v%0d_rd_en_lo", i), 32'(o_rd_en), 0);
            gap(2);
        end

        // Sync delay: value seen while strobe k is presented came in at strobe k-3.
        for (int k = 0; k < 120; k++) begin
            chk($sformatf("hs_k%0d", k), 32'(o_hs), (k - 3 >= 16 && k - 3 <= 111) ? 0 : 1);
            chk($sformatf("vs_k%0d", k), 32'(o_vs), (k - 3 >= 30 && k - 3 <= 40) ? 0 : 1);
            pulse(0, 0, (k >= 16 && k <= 111) ? 1'b0 : 1'b1, (k >= 30 && k <= 40) ? 1'b0 : 1'b1,
                  1'b0, 1'b0, 1'b0);
            gap(3);
        end

        // Page swap: two requests in one frame give a single flip at the animate strobe.
        pulse(0, 0, 1, 1, 0, 0, 1);
        chk("swap_req_page", 32'(o_page), 0);
        chk("swap_req_ack", 32'(o_swap_ack), 0);
        gap(3);
        pulse(0, 0, 1, 1, 0, 0, 0);
        gap(3);
        pulse(0, 0, 1, 1, 0, 0, 1);
        chk("swap_req2_page", 32'(o_page), 0);
        gap(3);
        pulse(0, 0, 1, 1, 0, 1, 0);
        chk("flip_ack", 32'(o_swap_ack), 1);
        chk("flip_page", 32'(o_page), 1);
        chk("flip_frame", 32'(o_frame), 1);
        gap(1);
        chk("flip_ack_pulse", 32'(o_swap_ack), 0);
        gap(2);
        pulse(0, 0, 1, 1, 1, 0, 0);
        chk("p1_addr0", 32'(o_rd_addr), 19200);
        gap(3);
        pulse(13, 9, 1, 1, 1, 0, 0);
        chk("p1_addr323", 32'(o_rd_addr), 19523);
        gap(3);
        pulse(0, 0, 1, 1, 0, 0, 0);
        chk("p1_rgb_a", 32'(o_rgb), 32'h0F0F);
        gap(3);
        pulse(0, 0, 1, 1, 0, 0, 0);
        chk("p1_rgb_b", 32'(o_rgb), 32'h0F0F);
        gap(3);
        pulse(0, 0, 1, 1, 0, 1, 0);
        chk("noreq_ack", 32'(o_swap_ack), 0);
        chk("noreq_page", 32'(o_page), 1);
        chk("noreq_frame", 32'(o_frame), 2);
        gap(3);
        pulse(0, 0, 1, 1, 0, 1, 1);
        chk("coinc_ack", 32'(o_swap_ack), 1);
        chk("coinc_page", 32'(o_page), 0);
        chk("coinc_frame", 32'(o_frame), 3);
        gap(3);
        pulse(0, 0, 1, 1, 0, 1, 0);
        chk("coinc_nopend_ack", 32'(o_swap_ack), 0);
        chk("coinc_nopend_page", 32'(o_page), 0);
        chk("coinc_nopend_frame", 32'(o_frame), 4);
        gap(3);
        pulse(0, 0, 1, 1, 0, 0, 1);
        gap(3);
        pulse(0, 0, 1, 1, 0, 1, 0);
        chk("reflip_page", 32'(o_page), 1);
        chk("reflip_frame", 32'(o_frame), 5);
        gap(3);

        // Frame counter wrap: animate held with a strobe on every clock.
        i_animate = 1'b1; i_pix_stb = 1'b1;
        repeat (65530) @(posedge i_clk);
        #1;
        chk("frame_ffff", 32'(o_frame), 32'hFFFF);
        @(posedge i_clk);
        #1;
        chk("frame_wrap", 32'(o_frame), 0);
        i_animate = 1'b0; i_pix_stb = 1'b0;
        gap(3);
        chk("wrap_page_hold", 32'(o_page), 1);

        // Reset mid-line, then refill.
        for (int i = 0; i < 3; i++) begin
            pulse(0, 0, 0, 0, 1, 0, 0);
            gap(3);
        end
        chk("pre_rst_rgb", 32'(o_rgb), 32'h0F0F);
        chk("pre_rst_hs", 32'(o_hs), 0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("mid_rst_rgb", 32'(o_rgb), 0);
        chk("mid_rst_hs", 32'(o_hs), 1);
        chk("mid_rst_vs", 32'(o_vs), 1);
        chk("mid_rst_page", 32'(o_page), 0);
        chk("mid_rst_frame", 32'(o_frame), 0);
        chk("mid_rst_rd_en", 32'(o_rd_en), 0);
        chk("mid_rst_addr", 32'(o_rd_addr), 0);
        i_rst = 1'b0;
        gap(2);
        pulse(0, 0, 0, 0, 1, 0, 0);
        chk("refill0_hs", 32'(o_hs), 1);
        gap(3);
        pulse(0, 0, 1, 1, 0, 0, 0);
        chk("refill1_rgb", 32'(o_rgb), 0);
        chk("refill1_hs", 32'(o_hs), 1);
        chk("refill1_vs", 32'(o_vs), 1);
        gap(3);
        pulse(0, 0, 1, 1, 0, 0, 0);
        chk("refill2_rgb", 32'(o_rgb), 32'h0ABC);
        chk("refill2_hs", 32'(o_hs), 0);
        chk("refill2_vs", 32'(o_vs), 0);
        gap(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
